// File: rtl/disp_1596.sv
// disp_1596: converts the 10-bit count to four BCD digits with an
// iterative shift-add-3 engine and drives a multiplexed, common-anode,
// 4-digit 7-segment display with optional leading-zero blanking.
module disp_1596 #(
    parameter int unsigned REFRESH_DIV = 5000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk5m,
    input  logic        rst_n,
    input  logic [9:0]  cnt,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [6:0]  seg_n,
    output logic [3:0]  dig_n
);

    localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  shreg_q, shreg_d;
    logic [9:0]  cap_q, cap_d;
    logic [9:0]  cnt_last_q, cnt_last_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic        busy_q, busy_d;
    logic [15:0] adj;

    logic [15:0] presc_q;
    logic [1:0]  idx_q;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  dig_q;
    logic [3:0]  nib;
    logic        blank;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Converter next-state: start on a changed input, ten shifts, then commit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cnt != cnt_last_q) state_d = S_SHIFT;
            S_SHIFT: if (iter_q == 4'd9) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every scratch nibble before each shift
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
        end
    end

    // Converter datapath and outputs per state
    always_comb begin
        shreg_d    = shreg_q;
        cap_d      = cap_q;
        cnt_last_d = cnt_last_q;
        scratch_d  = scratch_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (cnt != cnt_last_q) begin
                    shreg_d   = cnt;
                    cap_d     = cnt;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                end
            end
            S_SHIFT: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                iter_d = iter_q + 4'd1;
            end
            S_DONE: begin
                bcd_d      = scratch_q;
                cnt_last_d = cap_q;
                busy_d     = 1'b0;
            end
            default: ;
        endcase
    end

    // Converter datapath registers
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cap_q      <= '0;
            cnt_last_q <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cap_q      <= cap_d;
            cnt_last_q <= cnt_last_d;
            scratch_q  <= scratch_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
        end
    end

    // Digit selection and leading-zero blanking from the committed value
    always_comb begin
        nib   = bcd_q[idx_q*4 +: 4];
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx_q)
                2'd3:    blank = (bcd_q[15:12] == 4'd0);
                2'd2:    blank = (bcd_q[15:8] == 8'd0);
                2'd1:    blank = (bcd_q[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
        seg_d = blank ? 7'h7F : seg_of(nib);
    end

    // Refresh prescaler, digit scan and registered display outputs
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= 4'hF;
        end else begin
            if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
                idx_q   <= idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + 16'd1;
            end
            seg_q <= seg_d;
            dig_q <= ~(4'b0001 << idx_q);
        end
    end

    assign bcd   = bcd_q;
    assign busy  = busy_q;
    assign seg_n = seg_q;
    assign dig_n = dig_q;

endmodule

// File: tb/tb_disp_1596.sv
// Bench for disp_1596: two instances (blanking on / off) sharing one input,
// a queue-based scoreboard for conversions and a scan/segment model.
module tb_disp_1596;

    logic        clk5m = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  cnt   = '0;
    logic [15:0] bcd_b, bcd_u;
    logic        busy_b, busy_u;
    logic [6:0]  seg_b, seg_u;
    logic [3:0]  dig_b, dig_u;

    always #5 clk5m = ~clk5m;

    disp_1596 #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .clk5m(clk5m), .rst_n(rst_n), .cnt(cnt),
        .bcd(bcd_b), .busy(busy_b), .seg_n(seg_b), .dig_n(dig_b)
    );

    disp_1596 #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_u (
        .clk5m(clk5m), .rst_n(rst_n), .cnt(cnt),
        .bcd(bcd_u), .busy(busy_u), .seg_n(seg_u), .dig_n(dig_u)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Decimal digits of v in BCD, from plain arithmetic.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected active-low pattern for digit position d of value val.
    function automatic int exp_seg(input int val, input int d, input bit blz);
        int p;
        int digit;
        p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
        digit = (val / p) % 10;
        if (blz && d > 0 && val < p) return 'h7F;
        case (digit)
            0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
            4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
            8: return 'h00;  default: return 'h10;
        endcase
    endfunction

    typedef struct {
        int val;
        int dn;   // clock edge at which the result is committed
    } conv_t;

    conv_t sb_q[$];
    conv_t dq[$];

    int cyc = 0;   // posedges since time 0
    int k   = 0;   // posedges since last reset release
    int last_conv = 0;
    int idle_at   = 1;

    always @(posedge clk5m) cyc <= cyc + 1;
    always @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Drive v for h edges; a value is converted if it is present on some edge
    // at which the converter is free and it differs from the last converted one.
    task automatic apply(input int v, input int h);
        int    c;
        conv_t e;
        cnt = 10'(v);
        c = (cyc + 1 > idle_at) ? cyc + 1 : idle_at;
        if (c <= cyc + h && v != last_conv) begin
            e.val = v;
            e.dn  = c + 11;
            sb_q.push_back(e);
            dq.push_back(e);
            last_conv = v;
            idle_at   = c + 12;
        end
        repeat (h) @(posedge clk5m);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb_q.delete();
        dq.delete();
        last_conv = 0;
        #1;
        chk("rst_bcd", bcd_b, 0);
        chk("rst_busy", busy_b, 0);
        repeat (n) @(posedge clk5m);
        @(negedge clk5m);
        #2;
        rst_n   = 1'b1;
        idle_at = cyc + 1;
    endtask

    // Conversion monitor: each busy fall must deliver the next queued result.
    int busy_len  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk5m) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy_b) busy_len++;
            if (prev_busy && !busy_b) begin
                chk("busy_len", busy_len, 11);
                busy_len = 0;
                chk("conv_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    chk("bcd", bcd_b, to_bcd(sb_q[0].val));
                    chk("bcd_unblanked_inst", bcd_u, to_bcd(sb_q[0].val));
                    chk("done_edge", cyc, sb_q[0].dn);
                    void'(sb_q.pop_front());
                end
            end
            prev_busy = busy_b;
        end
    end

    // Display monitor: scan order, dwell of 4 cycles, segment content.
    int shown = 0;
    always @(negedge clk5m) begin
        int         idx;
        logic [3:0] ed;
        if (!rst_n) begin
            shown = 0;
            chk("rst_dig_b", dig_b, 'hF);
            chk("rst_seg_b", seg_b, 'h7F);
            chk("rst_dig_u", dig_u, 'hF);
            chk("rst_seg_u", seg_u, 'h7F);
        end else if (k > 0) begin
            idx = ((k - 1) / 4) % 4;
            ed  = ~(4'b0001 << idx);
            chk("dig_b", dig_b, ed);
            chk("dig_u", dig_u, ed);
            chk("seg_blank", seg_b, exp_seg(shown, idx, 1'b1));
            chk("seg_noblank", seg_u, exp_seg(shown, idx, 1'b0));
            if (dq.size() > 0 && dq[0].dn == cyc) begin
                shown = dq[0].val;
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        int v;
        #1;
        do_reset(3);
        apply(0, 20);                   // no conversion after reset with cnt = 0
        apply(1023, 30);                // maximum value
        apply(7, 40);                   // leading-zero blanking
        apply(500, 3);                  // change while busy
        apply(501, 30);
        apply(999, 6);                  // reset in the middle of shifting
        do_reset(2);
        apply(999, 30);
        apply(1023, 40);                // scan sequence
        apply(0, 40);
        apply(1023, 40);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 120));
            else                           v = int'($urandom_range(0, 1023));
            apply(v, int'($urandom_range(1, 20)));
        end
        apply(int'(cnt), 30);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("display_queue_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/disp_1596.md
Name: disp_1596

Overview:
Display stage directly downstream of count_1596. It consumes the 10-bit counter value and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives a time-multiplexed 4-digit common-anode 7-segment display. Runs in the clk5m domain; all outputs are registered.

Parameters:
REFRESH_DIV, 5000, clk5m cycles per digit slot (5000 gives a 1 kHz digit rate); legal range 2..65535.
BLANK_LZ, 1, 1 = blank leading zeros, 0 = always show all four digits.

Ports:
clk5m    in   1   system clock, 5 MHz
rst_n    in   1   asynchronous active-low reset
cnt      in   10  binary value from count_1596, 0..1023
bcd      out  16  converted value: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
busy     out  1   high while a conversion is in progress
seg_n    out  7   segments, active-low, bit order gfedcba
dig_n    out  4   digit enables, active-low one-hot; bit0 = ones ... bit3 = thousands

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE, cnt_last = 0, bcd = 16'h0000, busy = 0.
  - Prescaler = 0, digit index = 0, seg_n = 7'h7F, dig_n = 4'hF.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if cnt != cnt_last, capture cnt into a 10-bit shift register, clear the 16-bit scratch BCD, set iteration counter to 0, go to SHIFT, busy = 1.
  - IDLE: if cnt == cnt_last, stay in IDLE.
  - SHIFT, each cycle: first, every scratch nibble >= 5 gets +3 (all four nibbles in parallel). Then {scratch, shreg} shifts left by 1. Iteration counter increments. After the 10th shift, go to DONE.
  - DONE: bcd <= scratch, cnt_last <= captured value, busy <= 0, go to IDLE.
  - Latency: cnt changes at edge N; bcd is updated at edge N+12. busy is high from edge N+1 through edge N+11.
- cnt changes while busy: ignored until the FSM is back in IDLE. The new value is captured on the first IDLE cycle, with no extra wait. bcd never shows a partial result.
- Output range: 1023 -> 16'h1023; 0 -> 16'h0000. The thousands nibble is always 0 or 1.
- Reset mid-conversion: the conversion is aborted and all state returns to reset values. After release, if cnt != 0, a conversion starts on the first clock edge.
- Display prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, digit index advances 0->1->2->3->0.
- Display outputs:
  - Registered every cycle from the current digit index and bcd.
  - dig_n = ~(4'b0001 << index).
  - seg_n is the segment pattern of the selected nibble.
- Segment codes (hex, active-low gfedcba):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - Blank: 7F. Nibbles > 9 cannot occur; if one did, it displays blank.
- Leading-zero blanking (BLANK_LZ = 1):
  - Thousands is blanked if 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked.
  - A blanked digit outputs seg_n = 7F; dig_n still scans normally.
- The display always uses the last completed bcd, never the scratch register.

Test Plan:
- Reset check: assert rst_n = 0 with cnt = 0, then release. Expect bcd = 0000, busy = 0, seg_n = 7F and dig_n = F while in reset. After release, dig_n = E, seg_n = 40, and no conversion starts.
- Max value: drive cnt = 1023 at edge N. Expect busy high for edges N+1..N+11 and bcd = 16'h1023 at N+12. With REFRESH_DIV = 4, the digit sequence is ones/tens/hundreds/thousands = 30/24/40/79.
- Blanking: drive cnt = 7 with BLANK_LZ = 1. Expect bcd = 0007; seg_n = 78 on dig_n = E and 7F on D, B and 7. With BLANK_LZ = 0, expect 78, 40, 40, 40.
- Change while busy: drive cnt = 500, then cnt = 501 three cycles later. Expect bcd = 0500 at +12, then a second conversion starting immediately, and bcd = 0501 after 12 more cycles. No intermediate value appears.
- Reset mid-conversion: drive cnt = 999, then pulse rst_n low during SHIFT iteration 5. Expect bcd = 0000 and busy = 0 immediately. After release, a full conversion gives bcd = 0999.
- Scan timing: use REFRESH_DIV = 4 and a 1023→0→1023 count sequence. Expect each dig_n value held exactly 4 cycles, cycling E, D, B, 7, with exactly one digit enabled at a time.
